hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter: W, 32, operand and HI/LO width.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low; asserted (0) clears state immediately.
REQ-004 SHALL have port: start  input  1  request strobe, sampled when busy=0.
REQ-005 SHALL have port: op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-006 SHALL have port: a  input  W  rs operand / dividend / mthi-mtlo data.
REQ-007 SHALL have port: b  input  W  rt operand / divisor.
REQ-008 SHALL have port: kill  input  1  pipeline flush; aborts in-flight op.
REQ-009 SHALL have port: busy  output  1  operation in progress; pipeline stalls mfhi/mflo/muldiv while high.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on the edge HI/LO are written by mult/div.
REQ-011 SHALL have port: dz  output  1  one-cycle pulse with done when a div/divu had b=0.
REQ-012 SHALL have ports: hi, lo  output  W each  architectural HI/LO registers.

Function
REQ-013 SHALL accept start only when busy=0 and kill=0; start while busy=1 SHALL be ignored.
REQ-014 SHALL use FSM states IDLE, ITER, FIX; IDLE->ITER on accepted mult/multu/div/divu needing iteration, ITER->FIX after 32 iteration cycles, FIX->IDLE after one cycle.
REQ-015 SHALL, on accepted mthi/mtlo, write a into hi/lo on that edge, no busy, no done.
REQ-016 SHALL, for div/divu, assert busy from the edge after acceptance for exactly 33 cycles (32 ITER + 1 FIX); lo=quotient, hi=remainder written on the FIX-exit edge, busy falls and done pulses on that same edge.
REQ-017 SHALL perform an iterative restoring divide on magnitudes: one quotient bit per ITER cycle, MSB first; 6-bit iteration counter counts 0..31.
REQ-018 SHALL, for signed div, truncate quotient toward zero and give remainder the sign of the dividend (sign fix-up in FIX).
REQ-019 SHALL, for div with a=32'h8000_0000, b=32'hFFFF_FFFF, produce lo=32'h8000_0000, hi=0.
REQ-020 SHALL, for b=0 (div or divu), still take 33 cycles, write lo=32'hFFFF_FFFF, hi=a, pulse dz with done.
REQ-021 SHALL, for mult/multu, produce the full 2W-bit product into {hi,lo}, signed for mult, unsigned for multu.
REQ-022 SHALL, on kill=1 in any state, return to IDLE on that edge, deassert busy, leave hi/lo unchanged, and not pulse done/dz.
REQ-023 SHALL give kill priority over start when both are high in the same cycle.

Reset
REQ-024 SHALL, on reset=0, asynchronously force state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0, counter=0.
REQ-025 SHALL discard any in-flight operation when reset asserts mid-operation; after release, accept a new start next cycle.

Configuration
REQ-026 SHALL, with HILO_ITER_MULT_EN defined, perform mult/multu by 32-cycle shift-add on magnitudes through ITER/FIX, identical timing to div (busy 33 cycles, done pulse).
REQ-027 SHALL, without HILO_ITER_MULT_EN, compute mult/multu combinationally and write {hi,lo} on the acceptance edge with busy=0 and done pulsing the following cycle.

Structure
REQ-028 SHALL place the op encoding typedef (enum, 3 bits), the FSM state typedef and the ITER count constant 32 in shared package hilo_pkg.
REQ-029 SHALL place the iterative divide datapath (remainder/quotient shift registers, subtract-compare) in one sub-module div_iter; sign handling, FSM and HI/LO stay in hilo_unit.

Verification
REQ-030 SHALL check: div a=7, b=32'hFFFF_FFFE -> 33 busy cycles, then lo=32'hFFFF_FFFD, hi=1, done=1 one cycle, dz=0.
REQ-031 SHALL check: divu a=32'hFFFF_FFFF, b=16 -> lo=32'h0FFF_FFFF, hi=32'hF; then div a=5, b=0 -> lo=32'hFFFF_FFFF, hi=5, dz=1.
REQ-032 SHALL check: mult a=32'hFFFF_FFFD (-3), b=5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1; multu a=32'hFFFF_FFFF, b=2 -> hi=1, lo=32'hFFFF_FFFE; both with and without HILO_ITER_MULT_EN at the required latency.
REQ-033 SHALL check: mthi a=32'h1234_5678 then mtlo a=32'h9ABC_DEF0 -> hi/lo updated next edge, busy never asserted; start during busy ignored.
REQ-034 SHALL check: div started, kill=1 at ITER cycle 10 -> busy=0 next edge, hi/lo keep prior values, no done; new div accepted next cycle completes correctly.
REQ-035 SHALL check: reset=0 asserted asynchronously mid-ITER -> busy, hi, lo go 0 without a clock edge; div -2^31 / -1 after release -> lo=32'h8000_0000, hi=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// hilo_pkg -- shared definitions for the HI/LO multiply/divide unit.
//   op_e       : 3-bit operation encoding presented on hilo_unit.op
//   state_t    : FSM state type with ST_IDLE / ST_ITER / ST_FIX encodings
//   ITER_COUNT : number of iteration cycles spent in ST_ITER (one result bit each)
//   ITER_LAST  : final value reached by the 6-bit iteration counter
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ITER = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

    localparam int         ITER_COUNT = 32;
    localparam logic [5:0] ITER_LAST  = 6'(ITER_COUNT - 1);

    // Signed variants need magnitude conversion and a sign fix-up.
    function automatic logic is_signed_op(input op_e op_v);
        return (op_v == OP_MULT) || (op_v == OP_DIV);
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter -- restoring divider datapath on unsigned magnitudes.
//   clk, reset      : clock, asynchronous active-low reset
//   load            : capture dividend/divisor and clear the partial remainder
//   step            : produce one quotient bit, MSB first
//   dividend, divisor : W-bit unsigned magnitudes
//   quot, rem       : quotient / remainder after ITER_COUNT steps
// With divisor=0 every trial subtract succeeds, so the quotient becomes all
// ones and the remainder shifts in the whole dividend.
module div_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    logic [W-1:0] quot_r;
    logic [W-1:0] rem_r;
    logic [W-1:0] dsor_r;
    logic [W:0]   shifted_s;
    logic [W:0]   diff_s;

    // Trial subtract: bring down the next dividend bit and compare; diff_s[W] is the borrow.
    always_comb begin
        shifted_s = {rem_r, quot_r[W-1]};
        diff_s    = shifted_s - {1'b0, dsor_r};
    end

    // Remainder/quotient shift registers; quotient bits enter at the LSB as dividend bits leave the MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quot_r <= {W{1'b0}};
            rem_r  <= {W{1'b0}};
            dsor_r <= {W{1'b0}};
        end else if (load) begin
            quot_r <= dividend;
            rem_r  <= {W{1'b0}};
            dsor_r <= divisor;
        end else if (step) begin
            if (!diff_s[W]) begin
                rem_r  <= diff_s[W-1:0];
                quot_r <= {quot_r[W-2:0], 1'b1};
            end else begin
                rem_r  <= shifted_s[W-1:0];
                quot_r <= {quot_r[W-2:0], 1'b0};
            end
        end else begin
            quot_r <= quot_r;
            rem_r  <= rem_r;
            dsor_r <= dsor_r;
        end
    end

    assign quot = quot_r;
    assign rem  = rem_r;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit -- MIPS-style HI/LO multiply/divide unit.
//   clk, reset : clock, asynchronous active-low reset
//   start, op  : request strobe and operation (hilo_pkg::op_e), taken when busy=0
//   a, b       : rs/rt operands (dividend/divisor, or mthi/mtlo data on a)
//   kill       : pipeline flush; aborts any in-flight operation, wins over start
//   busy       : iterative operation in progress
//   done, dz   : one-cycle pulses when mult/div results land in HI/LO (dz: divide by zero)
//   hi, lo     : architectural HI/LO registers
// Build option HILO_ITER_MULT_EN: mult/multu run 32-cycle shift-add through
// ITER/FIX like divide. Without it the product is computed combinationally and
// written on the acceptance edge.
// The iteration count is fixed at 32, so W is expected to stay 32.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         kill,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
        return ~x + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
        return ~x + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    state_t       state_r;
    logic         busy_r;
    logic         done_r;
    logic         dz_r;
    logic [W-1:0] hi_r;
    logic [W-1:0] lo_r;
    logic [5:0]   cnt_r;
    logic         is_div_r;
    logic         q_neg_r;
    logic         r_neg_r;
    logic         dz_pend_r;
    logic [W-1:0] a_keep_r;

    op_e          op_s;
    logic         accept_s;
    logic         sgn_s;
    logic         a_neg_s;
    logic         b_neg_s;
    logic [W-1:0] a_mag_s;
    logic [W-1:0] b_mag_s;
    logic         is_div_op_s;
    logic         div_load_s;
    logic         div_step_s;
    logic [W-1:0] quot_s;
    logic [W-1:0] rem_s;

    assign op_s        = op_e'(op);
    assign accept_s    = start && !kill && !busy_r && (state_r == ST_IDLE);
    assign sgn_s       = is_signed_op(op_s);
    assign a_neg_s     = sgn_s && a[W-1];
    assign b_neg_s     = sgn_s && b[W-1];
    assign a_mag_s     = a_neg_s ? neg_w(a) : a;
    assign b_mag_s     = b_neg_s ? neg_w(b) : b;
    assign is_div_op_s = (op_s == OP_DIV) || (op_s == OP_DIVU);
    assign div_load_s  = accept_s && is_div_op_s;
    assign div_step_s  = (state_r == ST_ITER) && is_div_r;

    div_iter #(.W(W)) u_div_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load_s),
        .step     (div_step_s),
        .dividend (a_mag_s),
        .divisor  (b_mag_s),
        .quot     (quot_s),
        .rem      (rem_s)
    );

`ifdef HILO_ITER_MULT_EN
    logic [2*W-1:0] prod_r;
    logic [W-1:0]   mcand_r;
    logic [W:0]     psum_s;
    logic           mul_load_s;
    logic           mul_step_s;

    assign mul_load_s = accept_s && ((op_s == OP_MULT) || (op_s == OP_MULTU));
    assign mul_step_s = (state_r == ST_ITER) && !is_div_r;

    // Shift-add partial sum: add the multiplicand into the upper half when the current multiplier bit is set.
    always_comb begin
        if (prod_r[0]) begin
            psum_s = {1'b0, prod_r[2*W-1:W]} + {1'b0, mcand_r};
        end else begin
            psum_s = {1'b0, prod_r[2*W-1:W]};
        end
    end

    // Product register: multiplier magnitude starts in the low half and is consumed LSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_r  <= {(2*W){1'b0}};
            mcand_r <= {W{1'b0}};
        end else if (mul_load_s) begin
            prod_r  <= {{W{1'b0}}, b_mag_s};
            mcand_r <= a_mag_s;
        end else if (mul_step_s) begin
            prod_r  <= {psum_s, prod_r[W-1:1]};
            mcand_r <= mcand_r;
        end else begin
            prod_r  <= prod_r;
            mcand_r <= mcand_r;
        end
    end
`else
    logic [2*W-1:0] a_ext_s;
    logic [2*W-1:0] b_ext_s;
    logic [2*W-1:0] prod_s;

    // Sign- or zero-extend so a single 2W-bit multiply yields both signed and unsigned products.
    assign a_ext_s = sgn_s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    assign b_ext_s = sgn_s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    assign prod_s  = a_ext_s * b_ext_s;
`endif

    // Control FSM and architectural HI/LO; kill is checked first so it beats start and any result write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dz_r      <= 1'b0;
            hi_r      <= {W{1'b0}};
            lo_r      <= {W{1'b0}};
            cnt_r     <= 6'd0;
            is_div_r  <= 1'b0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
            dz_pend_r <= 1'b0;
            a_keep_r  <= {W{1'b0}};
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            if (kill) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                cnt_r   <= 6'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (accept_s) begin
                            case (op_s)
                                OP_MULT, OP_MULTU: begin
`ifdef HILO_ITER_MULT_EN
                                    state_r   <= ST_ITER;
                                    busy_r    <= 1'b1;
                                    cnt_r     <= 6'd0;
                                    is_div_r  <= 1'b0;
                                    q_neg_r   <= a_neg_s ^ b_neg_s;
                                    r_neg_r   <= 1'b0;
                                    dz_pend_r <= 1'b0;
`else
                                    {hi_r, lo_r} <= prod_s;
                                    done_r       <= 1'b1;
`endif
                                end
                                OP_DIV, OP_DIVU: begin
                                    state_r   <= ST_ITER;
                                    busy_r    <= 1'b1;
                                    cnt_r     <= 6'd0;
                                    is_div_r  <= 1'b1;
                                    // Quotient negative when signs differ; remainder follows the dividend.
                                    q_neg_r   <= a_neg_s ^ b_neg_s;
                                    r_neg_r   <= a_neg_s;
                                    dz_pend_r <= (b == {W{1'b0}});
                                    a_keep_r  <= a;
                                end
                                OP_MTHI: hi_r <= a;
                                OP_MTLO: lo_r <= a;
                                default: begin
                                    hi_r <= hi_r;
                                    lo_r <= lo_r;
                                end
                            endcase
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ITER: begin
                        if (cnt_r == ITER_LAST) begin
                            state_r <= ST_FIX;
                            cnt_r   <= 6'd0;
                        end else begin
                            cnt_r   <= cnt_r + 6'd1;
                        end
                    end
                    ST_FIX: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        if (is_div_r) begin
                            dz_r <= dz_pend_r;
                            if (dz_pend_r) begin
                                lo_r <= {W{1'b1}};
                                hi_r <= a_keep_r;
                            end else begin
                                lo_r <= q_neg_r ? neg_w(quot_s) : quot_s;
                                hi_r <= r_neg_r ? neg_w(rem_s) : rem_s;
                            end
                        end else begin
`ifdef HILO_ITER_MULT_EN
                            {hi_r, lo_r} <= q_neg_r ? neg_2w(prod_r) : prod_r;
`else
                            hi_r <= hi_r;
                            lo_r <= lo_r;
`endif
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign dz   = dz_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit -- directed self-checking bench for hilo_unit.
// Inputs change and outputs are sampled on the falling clock edge.
// Define HILO_ITER_MULT_EN consistently for RTL and bench to cover the iterative multiply build.
module tb_hilo_unit;
    import hilo_pkg::*;

`ifdef HILO_ITER_MULT_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        kill  = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_unit #(.W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request for a single clock; returns on the falling edge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Count remaining busy cycles (bounded), then check the result and the single done pulse.
    task automatic finish_op(input string tag, input int lat, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic edz);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".lat"}, 64'(n), 64'(lat));
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".dz"}, 64'(dz), 64'(edz));
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({tag, ".done_off"}, 64'(done), 64'd0);
        chk({tag, ".dz_off"}, 64'(dz), 64'd0);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dz", 64'(dz), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        reset = 1'b1;

        // Signed divide: 7 / -2 = -3 remainder 1.
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        finish_op("div_7_m2", 33, 32'd1, 32'hFFFF_FFFD, 1'b0);

        // Unsigned divide.
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
        finish_op("divu", 33, 32'hF, 32'h0FFF_FFFF, 1'b0);

        // Divide by zero.
        issue(OP_DIV, 32'd5, 32'd0);
        finish_op("div_by0", 33, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // Negative dividend: -7 / 2 = -3 remainder -1.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_m7_2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        // Signed and unsigned multiply.
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        finish_op("mult", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        finish_op("multu", MUL_LAT, 32'd1, 32'hFFFF_FFFE, 1'b0);

        // Moves into HI and LO.
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi.hi", 64'(hi), 64'h1234_5678);
        chk("mthi.busy", 64'(busy), 64'd0);
        chk("mthi.done", 64'(done), 64'd0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        chk("mtlo.lo", 64'(lo), 64'h9ABC_DEF0);
        chk("mtlo.hi", 64'(hi), 64'h1234_5678);
        chk("mtlo.busy", 64'(busy), 64'd0);
        chk("mtlo.done", 64'(done), 64'd0);

        // A start while busy is ignored: 100 / 7 = 14 remainder 2.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        chk("ign.hi", 64'(hi), 64'h1234_5678);
        chk("ign.busy", 64'(busy), 64'd1);
        finish_op("ign_div", 29, 32'd2, 32'd14, 1'b0);

        // Kill at ITER cycle 10, then an immediate new divide: 9 / 2 = 4 remainder 1.
        issue(OP_DIV, 32'd9, 32'd2);
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill.busy", 64'(busy), 64'd0);
        chk("kill.done", 64'(done), 64'd0);
        chk("kill.hi", 64'(hi), 64'd2);
        chk("kill.lo", 64'(lo), 64'd14);
        issue(OP_DIV, 32'd9, 32'd2);
        finish_op("after_kill", 33, 32'd1, 32'd4, 1'b0);

        // Kill and start together: the move must not happen.
        @(negedge clk);
        kill  = 1'b1;
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h5555_5555;
        @(negedge clk);
        kill  = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        chk("kprio.hi", 64'(hi), 64'd1);
        chk("kprio.busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of ITER clears state between clock edges.
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst.busy", 64'(busy), 64'd0);
        chk("arst.hi", 64'(hi), 64'd0);
        chk("arst.lo", 64'(lo), 64'd0);
        chk("arst.done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Overflow case -2^31 / -1.
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 33, 32'd0, 32'h8000_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
